psram_opi_slv: RTL and testbench

- Synthesizable octal-DDR PSRAM target (responder) for the far end of the psram_if pin bus; the psram_core controller is the initiator.
- Oversamples SCK, CE#, IO and DQS with the local clock, then decodes command, address, latency and data beats.
- Serves bursts from a byte-wide backing-memory port plus an 8-entry mode-register file.
- Used as a bench/FPGA device model and as a loopback target for the controller.

---
 rtl/psram_opi_pkg.sv | 22 ++
 rtl/psram_opi_slv_if.sv | 21 ++
 rtl/psram_opi_sync.sv | 42 ++++
 rtl/psram_opi_slv.sv | 186 ++++++++++++++++++
 tb/tb_psram_opi_slv.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_opi_pkg.sv
// Shared types and default command codes for the octal-DDR PSRAM target.
package psram_opi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LAT,
    S_WDAT,
    S_RDAT,
    S_MRW,
    S_IGN
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'hA0;
  localparam logic [7:0] CMD_RD  = 8'h20;
  localparam logic [7:0] CMD_MRW = 8'hC0;
  localparam logic [7:0] CMD_MRR = 8'h40;

  localparam int MR_NUM = 8;

endpackage

// File: rtl/psram_opi_slv_if.sv
// PSRAM pin bus between the controller (master) and this target (slave).
interface psram_opi_slv_if;
  logic       psram_sck_i;
  logic       psram_ce_i;
  logic [7:0] psram_io_in_i;
  logic [7:0] psram_io_out_o;
  logic [7:0] psram_io_en_o;
  logic       psram_dqs_in_i;
  logic       psram_dqs_out_o;
  logic       psram_dqs_en_o;

  modport master (
    output psram_sck_i, psram_ce_i, psram_io_in_i, psram_dqs_in_i,
    input  psram_io_out_o, psram_io_en_o, psram_dqs_out_o, psram_dqs_en_o
  );

  modport slave (
    input  psram_sck_i, psram_ce_i, psram_io_in_i, psram_dqs_in_i,
    output psram_io_out_o, psram_io_en_o, psram_dqs_out_o, psram_dqs_en_o
  );
endinterface

// File: rtl/psram_opi_sync.sv
// Oversampling front end: every bus pin goes through the same 2-flop
// synchronizer so IO/DQS stay aligned with the SCK edge that carries them.
module psram_opi_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce,
  input  logic [7:0] io,
  input  logic       dqs,
  output logic       beat,
  output logic       ce_fall,
  output logic       ce_rise,
  output logic [7:0] io_s,
  output logic       dqs_s
);
  // [0],[1] synchronize; [2] is the previous synchronized level for edge detect
  logic [2:0]      sck_q, ce_q;
  logic [1:0]      dqs_q;
  logic [1:0][7:0] io_q;

  // Synchronizer chain; CE# resets high so reset release is not seen as a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= '0;
      ce_q  <= '1;
      dqs_q <= '0;
      io_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ce_q  <= {ce_q[1:0], ce};
      dqs_q <= {dqs_q[0], dqs};
      io_q  <= {io_q[0], io};
    end
  end

  // An SCK edge in the cycle CE# goes high is masked because ce_q[1] is already 1
  assign beat    = (sck_q[1] ^ sck_q[2]) & ~ce_q[1];
  assign ce_fall = ~ce_q[1] & ce_q[2];
  assign ce_rise = ce_q[1] & ~ce_q[2];
  assign io_s    = io_q[1];
  assign dqs_s   = dqs_q[1];
endmodule

// File: rtl/psram_opi_slv.sv
// Octal-DDR PSRAM target: decodes command/address/latency beats and serves
// bursts from a byte-wide backing memory plus an 8-entry mode-register file.
module psram_opi_slv
  import psram_opi_pkg::*;
#(
  parameter int         MEM_AW  = 16,
  parameter logic [7:0] WCMD    = CMD_WR,
  parameter logic [7:0] RCMD    = CMD_RD,
  parameter logic [7:0] MRW_CMD = CMD_MRW,
  parameter logic [7:0] MRR_CMD = CMD_MRR,
  parameter int         LAT_WR  = 4,
  parameter int         LAT_RD  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  psram_opi_slv_if.slave    bus,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam int                LCW   = 8;
  localparam logic [LCW-1:0]    LD_WR = LCW'(2*LAT_WR-1);
  localparam logic [LCW-1:0]    LD_RD = LCW'(2*LAT_RD-1);
  localparam logic [MEM_AW-1:0] A_ONE = MEM_AW'(1);

  logic       beat, ce_fall, ce_rise, dqs;
  logic [7:0] io;

  psram_opi_sync u_sync (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .sck    (bus.psram_sck_i),
    .ce     (bus.psram_ce_i),
    .io     (bus.psram_io_in_i),
    .dqs    (bus.psram_dqs_in_i),
    .beat   (beat),
    .ce_fall(ce_fall),
    .ce_rise(ce_rise),
    .io_s   (io),
    .dqs_s  (dqs)
  );

  state_e                 state;
  logic [7:0]             cmd;
  logic [1:0]             bcnt;
  logic [LCW-1:0]         lcnt;
  logic [MEM_AW-1:0]      addr, addr_nxt;
  logic [7:0]             pf, rd_byte, io_out, io_en;
  logic                   rd_pend, dqs_out, dqs_en;
  logic [MR_NUM-1:0][7:0] mr;
  logic                   cmd_ok, is_rd, is_mrr, rd_beat;

  // Address bytes arrive MSB first; shifting and truncating keeps the low MEM_AW bits
  assign addr_nxt = MEM_AW'({addr, io});
  assign cmd_ok   = (io == cmd) && (io inside {WCMD, RCMD, MRW_CMD, MRR_CMD});
  assign is_mrr   = (cmd == MRR_CMD);
  assign is_rd    = (cmd == RCMD) || is_mrr;
  // Bypass the prefetch register when the byte lands in the same cycle as the beat
  assign rd_byte  = is_mrr ? mr[addr[2:0]] : (rd_pend ? mem_rdata_i : pf);
  assign rd_beat  = beat && (((state == S_LAT) && (lcnt == '0) && is_rd) ||
                             (state == S_RDAT));

  // Prefetch capture: read data is valid one cycle after the request strobe
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_pend <= 1'b0;
      pf      <= '0;
    end else begin
      rd_pend <= mem_req_o & ~mem_we_o;
      if (rd_pend) pf <= mem_rdata_i;
    end
  end

  // Main protocol FSM with registered bus and memory outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cmd         <= '0;
      bcnt        <= '0;
      lcnt        <= '0;
      addr        <= '0;
      mr          <= '0;
      io_out      <= '0;
      io_en       <= '0;
      dqs_out     <= 1'b0;
      dqs_en      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      mem_req_o <= 1'b0;
      err_o     <= 1'b0;
      if (ce_rise) begin
        // Deselect aborts everything; only a transfer cut before data is an error
        err_o   <= state inside {S_CMD, S_ADDR, S_LAT};
        state   <= S_IDLE;
        io_en   <= '0;
        io_out  <= '0;
        dqs_en  <= 1'b0;
        dqs_out <= 1'b0;
      end else begin
        if (rd_beat) begin
          io_out  <= rd_byte;
          io_en   <= '1;
          dqs_out <= ~dqs_out;
          if (!is_mrr) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= addr;
            addr       <= addr + A_ONE;
          end
        end
        case (state)
          S_IDLE: if (ce_fall) begin
            state <= S_CMD;
            bcnt  <= '0;
          end
          S_CMD: if (beat) begin
            if (bcnt == 2'd0) begin
              cmd  <= io;
              bcnt <= 2'd1;
            end else if (cmd_ok) begin
              state <= S_ADDR;
              bcnt  <= 2'd0;
            end else begin
              err_o <= 1'b1;
              state <= S_IGN;
            end
          end
          S_ADDR: if (beat) begin
            addr <= addr_nxt;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (cmd == MRW_CMD) begin
                state <= S_MRW;
              end else begin
                state <= S_LAT;
                lcnt  <= is_rd ? LD_RD : LD_WR;
                if (is_rd) begin
                  dqs_en  <= 1'b1;
                  dqs_out <= 1'b0;
                end
                if (cmd == RCMD) begin
                  mem_req_o  <= 1'b1;
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= addr_nxt;
                  addr       <= addr_nxt + A_ONE;
                end
              end
            end
          end
          S_LAT: if (beat) begin
            if (lcnt == '0) state <= is_rd ? S_RDAT : S_WDAT;
            else            lcnt  <= lcnt - LCW'(1);
          end
          S_WDAT: if (beat) begin
            if (!dqs) begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= addr;
              mem_wdata_o <= io;
            end
            addr <= addr + A_ONE;
          end
          S_MRW: if (beat) begin
            mr[addr[2:0]] <= io;
            state         <= S_IGN;
          end
          default: ; // S_RDAT is served by rd_beat; S_IGN waits for deselect
        endcase
      end
    end
  end

  assign bus.psram_io_out_o  = io_out;
  assign bus.psram_io_en_o   = io_en;
  assign bus.psram_dqs_out_o = dqs_out;
  assign bus.psram_dqs_en_o  = dqs_en;
  assign busy_o              = (state != S_IDLE);
endmodule

// File: tb/tb_psram_opi_slv.sv
// Bench for psram_opi_slv: drives the pin bus as a controller would, keeps a
// byte-array reference of memory and mode registers, and checks every beat.
module tb_psram_opi_slv;
  localparam int         LAT_WR = 4;
  localparam int         LAT_RD = 6;
  localparam logic [7:0] WC  = 8'hA0;
  localparam logic [7:0] RC  = 8'h20;
  localparam logic [7:0] MWC = 8'hC0;
  localparam logic [7:0] MRC = 8'h40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psram_opi_slv_if bus();
  logic        mem_req, mem_we, busy, err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  psram_opi_slv #(.MEM_AW(16), .LAT_WR(LAT_WR), .LAT_RD(LAT_RD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .err_o(err)
  );

  // Backing memory seen by the DUT, plus activity counters
  logic [7:0]  mem [0:65535];
  logic [23:0] wlog [$];
  int req_cnt = 0, err_cnt = 0, ioen_cnt = 0;
  always @(posedge clk) begin
    if (mem_req) begin
      req_cnt++;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wlog.push_back({mem_addr, mem_wdata});
      end else mem_rdata <= mem[mem_addr];
    end
    if (err) err_cnt++;
    if (bus.psram_io_en_o != 8'h00) ioen_cnt++;
  end

  // Reference model: what the memory and mode registers must hold
  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_mr  [0:7];
  logic [7:0] wd [8];
  logic       wm [8];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic m);
    bus.psram_io_in_i  = d;
    bus.psram_dqs_in_i = m;
    repeat (2) @(negedge clk);
    bus.psram_sck_i = ~bus.psram_sck_i;
    repeat (4) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] c0, input logic [7:0] c1);
    bus.psram_ce_i = 1'b0;
    repeat (4) @(negedge clk);
    beat(c0, 1'b0);
    beat(c1, 1'b0);
  endtask

  task automatic send_addr(input logic [31:0] a);
    for (int i = 0; i < 4; i++) beat(a[31-8*i -: 8], 1'b0);
  endtask

  task automatic stop();
    bus.psram_ce_i = 1'b1;
    repeat (6) @(negedge clk);
    bus.psram_sck_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input int n);
    int w0, e0;
    logic [15:0] aa;
    logic [23:0] exp_w [$];
    w0 = wlog.size();
    e0 = err_cnt;
    start(WC, WC);
    send_addr(a);
    for (int i = 0; i < 2*LAT_WR; i++) beat(8'hEE, 1'b0);
    chk("wr_no_early", 64'(wlog.size() - w0), 64'(0));
    for (int k = 0; k < n; k++) begin
      aa = 16'(a + 32'(k));
      beat(wd[k], wm[k]);
      if (!wm[k]) begin
        exp_w.push_back({aa, wd[k]});
        ref_mem[aa] = wd[k];
      end
    end
    stop();
    chk("wr_count", 64'(wlog.size() - w0), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++)
      if (w0 + k < wlog.size()) chk("wr_addr_data", 64'(wlog[w0+k]), 64'(exp_w[k]));
    chk("wr_err", 64'(err_cnt - e0), 64'(0));
  endtask

  task automatic do_read(input logic [7:0] c, input logic [31:0] a, input int n);
    int e0, r0;
    logic [7:0] exp;
    e0 = err_cnt;
    r0 = req_cnt;
    start(c, c);
    send_addr(a);
    for (int i = 0; i < 2*LAT_RD-1; i++) beat(8'h00, 1'b0);
    chk("rd_preamble", 64'({bus.psram_dqs_en_o, bus.psram_dqs_out_o, bus.psram_io_en_o}),
        64'({1'b1, 1'b0, 8'h00}));
    for (int k = 0; k < n; k++) begin
      beat(8'h00, 1'b0);
      exp = (c == MRC) ? ref_mr[a[2:0]] : ref_mem[16'(a + 32'(k))];
      chk("rd_data", 64'(bus.psram_io_out_o), 64'(exp));
      chk("rd_strobe", 64'({bus.psram_io_en_o, bus.psram_dqs_out_o}),
          64'({8'hFF, (k % 2 == 0)}));
    end
    stop();
    chk("rd_release", 64'({bus.psram_io_en_o, bus.psram_dqs_en_o}), 64'(0));
    chk("rd_err", 64'(err_cnt - e0), 64'(0));
    if (c == MRC) chk("mrr_no_mem", 64'(req_cnt - r0), 64'(0));
  endtask

  typedef struct {
    logic [7:0] c0, c1;
    int         extra;
    int         err_cmd;
    int         err_rel;
  } cmd_vec_t;

  cmd_vec_t cv [8];

  initial begin
    int e0, r0, i0, n;
    logic [7:0] v;
    logic [31:0] a;

    cv[0] = '{WC,    WC,    0, 0, 1};
    cv[1] = '{RC,    RC,    0, 0, 1};
    cv[2] = '{MWC,   MWC,   2, 0, 1};
    cv[3] = '{MRC,   MRC,   0, 0, 1};
    cv[4] = '{8'h77, 8'h77, 6, 1, 0};
    cv[5] = '{WC,    RC,    6, 1, 0};
    cv[6] = '{8'h00, 8'h00, 6, 1, 0};
    cv[7] = '{8'hFF, 8'hFF, 6, 1, 0};

    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 8; i++) ref_mr[i] = 8'h00;

    bus.psram_ce_i = 1'b1;
    bus.psram_sck_i = 1'b0;
    bus.psram_io_in_i = 8'h00;
    bus.psram_dqs_in_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata, bus.psram_io_out_o,
        bus.psram_io_en_o, bus.psram_dqs_out_o, bus.psram_dqs_en_o, busy, err}), 64'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Command decode table
    for (int t = 0; t < 8; t++) begin
      e0 = err_cnt; r0 = req_cnt; i0 = ioen_cnt;
      start(cv[t].c0, cv[t].c1);
      chk("cmd_err", 64'(err_cnt - e0), 64'(cv[t].err_cmd));
      chk("cmd_busy", 64'(busy), 64'(1));
      for (int b = 0; b < cv[t].extra; b++) beat(8'h5C, 1'b0);
      e0 = err_cnt;
      stop();
      chk("cmd_rel_err", 64'(err_cnt - e0), 64'(cv[t].err_rel));
      chk("cmd_idle", 64'(busy), 64'(0));
      chk("cmd_no_mem", 64'(req_cnt - r0), 64'(0));
      chk("cmd_no_drive", 64'(ioen_cnt - i0), 64'(0));
    end

    // Masked write to 0x10, read back, then full write and read back
    for (int k = 0; k < 8; k++) begin
      wd[k] = 8'(8'h11 * (k + 1));
      wm[k] = (k == 2) || (k == 5);
    end
    do_write(32'h0000_0010, 8);
    do_read(RC, 32'h0000_0010, 8);
    for (int k = 0; k < 8; k++) wm[k] = 1'b0;
    do_write(32'h0000_0010, 8);
    do_read(RC, 32'h0000_0010, 8);

    // Address wrap at the top of memory
    for (int k = 0; k < 4; k++) begin
      wd[k] = 8'(8'hC1 + k);
      wm[k] = 1'b0;
    end
    do_write(32'h0000_FFFE, 4);
    do_read(RC, 32'h0000_FFFE, 4);

    // Mode registers: write MR3 and read all eight back
    e0 = err_cnt; r0 = req_cnt;
    start(MWC, MWC);
    send_addr(32'h0000_0003);
    beat(8'h5A, 1'b0);
    beat(8'hA5, 1'b0);
    stop();
    ref_mr[3] = 8'h5A;
    chk("mrw_no_mem", 64'(req_cnt - r0), 64'(0));
    chk("mrw_err", 64'(err_cnt - e0), 64'(0));
    for (int r = 0; r < 8; r++) do_read(MRC, 32'(r), 2);

    // Deselect in the middle of the address phase
    e0 = err_cnt;
    start(RC, RC);
    beat(8'h00, 1'b0);
    beat(8'h00, 1'b0);
    bus.psram_ce_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("addr_abort_busy", 64'(busy), 64'(0));
    chk("addr_abort_err", 64'(err_cnt - e0), 64'(1));
    bus.psram_sck_i = 1'b0;
    repeat (4) @(negedge clk);

    // Random bursts against the reference model, some straddling the wrap
    for (int t = 0; t < 10; t++) begin
      a = (($urandom_range(0, 3) == 0) ? 32'h1234_FFF8 + 32'($urandom_range(0, 7)) : $urandom);
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) begin
          wd[k] = 8'($urandom);
          wm[k] = ($urandom_range(0, 3) == 0);
        end
        do_write(a, n);
      end
      do_read(RC, a, n);
    end

    // Reset asserted mid read burst
    start(RC, RC);
    send_addr(32'h0000_0040);
    for (int i = 0; i < 2*LAT_RD + 2; i++) beat(8'h00, 1'b0);
    chk("pre_reset_driving", 64'(bus.psram_io_en_o), 64'(8'hFF));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_read", 64'({mem_req, mem_we, mem_addr, mem_wdata, bus.psram_io_out_o,
        bus.psram_io_en_o, bus.psram_dqs_out_o, bus.psram_dqs_en_o, busy, err}), 64'(0));
    bus.psram_ce_i = 1'b1;
    bus.psram_sck_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(RC, 32'h0000_0010, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
